// File: rtl/seq_datapath.sv
// Self-sequencing datapath: one command per valid/ready handshake, internal FSM
// steps register read, ALU execute and write-back without external strobes.
module seq_datapath #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREG  = 8,
  parameter int unsigned PCW   = 8,
  localparam int unsigned RAW  = $clog2(NREG)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [RAW-1:0]   i_cmd_rd,
  input  logic [RAW-1:0]   i_cmd_rn,
  input  logic [RAW-1:0]   i_cmd_rm,
  input  logic [1:0]       i_cmd_shift,
  input  logic [1:0]       i_cmd_aluop,
  input  logic             i_cmd_asel,
  input  logic             i_cmd_bsel,
  input  logic [1:0]       i_cmd_wsrc,
  input  logic             i_cmd_wen,
  input  logic             i_cmd_sen,
  input  logic [WIDTH-1:0] i_cmd_imm,
  input  logic [WIDTH-1:0] i_cmd_mdata,
  input  logic [PCW-1:0]   i_cmd_pc,
  output logic             o_done,
  output logic [WIDTH-1:0] o_datapath_out,
  output logic [2:0]       o_status_out,
  input  logic [RAW-1:0]   i_dbg_addr,
  output logic [WIDTH-1:0] o_dbg_data
);

  typedef enum logic [2:0] {StIdle, StRdA, StRdB, StExec, StWb} state_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_rf [NREG];
  logic [WIDTH-1:0] r_a, r_b, r_c;
  logic [2:0]       r_status;

  logic [RAW-1:0]   r_rd, r_rn, r_rm;
  logic [1:0]       r_shift, r_aluop, r_wsrc;
  logic             r_asel, r_bsel, r_wen, r_sen;
  logic [WIDTH-1:0] r_imm, r_mdata;
  logic [PCW-1:0]   r_pc;

  logic             w_accept;
  logic [WIDTH-1:0] w_shifted, w_aop, w_bop, w_res, w_wb_val;
  logic             w_ovf;

  assign o_cmd_ready    = (r_state == StIdle);
  assign o_done         = (r_state == StWb);
  assign w_accept       = i_cmd_valid && o_cmd_ready;
  assign o_datapath_out = r_c;
  assign o_status_out   = r_status;
  assign o_dbg_data     = r_rf[i_dbg_addr];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: if (i_cmd_valid) w_state_nxt = (i_cmd_wsrc == 2'b00) ? StRdA : StWb;
      StRdA:  w_state_nxt = StRdB;
      StRdB:  w_state_nxt = StExec;
      StExec: w_state_nxt = StWb;
      StWb:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_shifted = r_b;
    case (r_shift)
      2'b01:   w_shifted = {r_b[WIDTH-2:0], 1'b0};
      2'b10:   w_shifted = {1'b0, r_b[WIDTH-1:1]};
      2'b11:   w_shifted = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
      default: w_shifted = r_b;
    endcase
  end

  assign w_aop = r_asel ? '0 : r_a;
  assign w_bop = r_bsel ? r_imm : w_shifted;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (r_aluop)
      2'b00: begin
        w_res = w_aop + w_bop;
        w_ovf = (w_aop[WIDTH-1] == w_bop[WIDTH-1]) && (w_res[WIDTH-1] != w_aop[WIDTH-1]);
      end
      2'b01: begin
        w_res = w_aop - w_bop;
        w_ovf = (w_aop[WIDTH-1] != w_bop[WIDTH-1]) && (w_res[WIDTH-1] != w_aop[WIDTH-1]);
      end
      2'b10:   w_res = w_aop & w_bop;
      default: w_res = ~w_bop;
    endcase
  end

  always_comb begin
    w_wb_val = r_c;
    case (r_wsrc)
      2'b01:   w_wb_val = r_mdata;
      2'b10:   w_wb_val = r_imm;
      2'b11:   w_wb_val = WIDTH'(r_pc);
      default: w_wb_val = r_c;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state  <= StIdle;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_status <= '0;
      for (int i = 0; i < int'(NREG); i++) r_rf[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == StRdA) r_a <= r_rf[r_rn];
      if (r_state == StRdB) r_b <= r_rf[r_rm];
      if (r_state == StExec) begin
        r_c <= w_res;
        if (r_sen) r_status <= {(w_res == '0), w_ovf, w_res[WIDTH-1]};
      end
      if ((r_state == StWb) && r_wen) r_rf[r_rd] <= w_wb_val;
    end
  end

  // Command fields are only consumed after acceptance, so they need no reset.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_rd    <= i_cmd_rd;
      r_rn    <= i_cmd_rn;
      r_rm    <= i_cmd_rm;
      r_shift <= i_cmd_shift;
      r_aluop <= i_cmd_aluop;
      r_asel  <= i_cmd_asel;
      r_bsel  <= i_cmd_bsel;
      r_wsrc  <= i_cmd_wsrc;
      r_wen   <= i_cmd_wen;
      r_sen   <= i_cmd_sen;
      r_imm   <= i_cmd_imm;
      r_mdata <= i_cmd_mdata;
      r_pc    <= i_cmd_pc;
    end
  end

endmodule

// File: tb/tb_seq_datapath.sv
// Bench for seq_datapath: a 16-bit/8-reg and a 32-bit/16-reg instance share one stimulus bus.
module tb_seq_datapath;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid;
  logic [3:0]  c_rd, c_rn, c_rm, dbg_addr;
  logic [1:0]  c_shift, c_aluop, c_wsrc;
  logic        c_asel, c_bsel, c_wen, c_sen;
  logic [31:0] c_imm, c_mdata;
  logic [7:0]  c_pc;

  logic        ready16, done16, ready32, done32;
  logic [15:0] dout16, dbg16;
  logic [31:0] dout32, dbg32;
  logic [2:0]  st16, st32;

  seq_datapath #(.WIDTH(16), .NREG(8), .PCW(8)) dut16 (
    .i_clk(clk), .i_reset_n(rst_n), .i_cmd_valid(valid), .o_cmd_ready(ready16),
    .i_cmd_rd(c_rd[2:0]), .i_cmd_rn(c_rn[2:0]), .i_cmd_rm(c_rm[2:0]),
    .i_cmd_shift(c_shift), .i_cmd_aluop(c_aluop), .i_cmd_asel(c_asel), .i_cmd_bsel(c_bsel),
    .i_cmd_wsrc(c_wsrc), .i_cmd_wen(c_wen), .i_cmd_sen(c_sen), .i_cmd_imm(c_imm[15:0]),
    .i_cmd_mdata(c_mdata[15:0]), .i_cmd_pc(c_pc), .o_done(done16), .o_datapath_out(dout16),
    .o_status_out(st16), .i_dbg_addr(dbg_addr[2:0]), .o_dbg_data(dbg16)
  );

  seq_datapath #(.WIDTH(32), .NREG(16), .PCW(8)) dut32 (
    .i_clk(clk), .i_reset_n(rst_n), .i_cmd_valid(valid), .o_cmd_ready(ready32),
    .i_cmd_rd(c_rd), .i_cmd_rn(c_rn), .i_cmd_rm(c_rm),
    .i_cmd_shift(c_shift), .i_cmd_aluop(c_aluop), .i_cmd_asel(c_asel), .i_cmd_bsel(c_bsel),
    .i_cmd_wsrc(c_wsrc), .i_cmd_wen(c_wen), .i_cmd_sen(c_sen), .i_cmd_imm(c_imm),
    .i_cmd_mdata(c_mdata), .i_cmd_pc(c_pc), .o_done(done32), .o_datapath_out(dout32),
    .o_status_out(st32), .i_dbg_addr(dbg_addr), .o_dbg_data(dbg32)
  );

  // Selected instance under check
  logic        sel32 = 1'b0;
  logic        ready_s, done_s;
  logic [31:0] dout_s, dbg_s;
  logic [2:0]  st_s;
  assign ready_s = sel32 ? ready32 : ready16;
  assign done_s  = sel32 ? done32 : done16;
  assign dout_s  = sel32 ? dout32 : {16'h0, dout16};
  assign dbg_s   = sel32 ? dbg32 : {16'h0, dbg16};
  assign st_s    = sel32 ? st32 : st16;

  int done_cnt = 0;
  always @(posedge clk) if (done_s === 1'b1) done_cnt <= done_cnt + 1;

  typedef struct {
    logic [3:0]  rd, rn, rm;
    logic [1:0]  shift, aluop, wsrc;
    logic        asel, bsel, wen, sen;
    logic [31:0] imm, mdata;
    logic [7:0]  pc;
  } cmd_t;

  typedef struct {
    cmd_t        c;
    int          lat;
    logic [31:0] rf_exp, dout_exp;
    logic [2:0]  st_exp;
  } vec_t;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk(input int rd, rn, rm, sh, op, asel, bsel, ws, wen, sen,
                              input logic [31:0] imm, mdata, input logic [7:0] pc);
    cmd_t c;
    c.rd = 4'(rd); c.rn = 4'(rn); c.rm = 4'(rm); c.shift = 2'(sh); c.aluop = 2'(op);
    c.asel = 1'(asel); c.bsel = 1'(bsel); c.wsrc = 2'(ws); c.wen = 1'(wen); c.sen = 1'(sen);
    c.imm = imm; c.mdata = mdata; c.pc = pc;
    return c;
  endfunction

  function automatic cmd_t rand_cmd(input int nreg);
    cmd_t c;
    c.rd = 4'($urandom % nreg); c.rn = 4'($urandom % nreg); c.rm = 4'($urandom % nreg);
    c.shift = 2'($urandom); c.aluop = 2'($urandom);
    c.asel = ($urandom % 4) == 0; c.bsel = ($urandom % 4) == 0;
    c.wsrc = ($urandom % 2) ? 2'b00 : 2'($urandom_range(3, 1));
    c.wen = ($urandom % 5) != 0; c.sen = ($urandom % 2) != 0;
    c.imm = $urandom; c.mdata = $urandom; c.pc = 8'($urandom);
    return c;
  endfunction

  task automatic drive(input cmd_t c);
    c_rd = c.rd; c_rn = c.rn; c_rm = c.rm; c_shift = c.shift; c_aluop = c.aluop;
    c_asel = c.asel; c_bsel = c.bsel; c_wsrc = c.wsrc; c_wen = c.wen; c_sen = c.sen;
    c_imm = c.imm; c_mdata = c.mdata; c_pc = c.pc;
  endtask

  // Reference model: architectural effect of one command, signed arithmetic on longints
  int         W = 16;
  longint     m_rf [16];
  longint     m_c;
  logic [2:0] m_st;

  function automatic longint sgn(input longint x);
    longint half = longint'(1) << (W - 1);
    return (x >= half) ? x - (half << 1) : x;
  endfunction

  task automatic model_reset();
    foreach (m_rf[i]) m_rf[i] = 0;
    m_c = 0;
    m_st = 3'b000;
  endtask

  task automatic model(input cmd_t c);
    longint msk = (longint'(1) << W) - 1;
    longint half = longint'(1) << (W - 1);
    longint a, b, full, r, val;
    logic v;
    if (c.wsrc == 2'b00) begin
      a = c.asel ? 0 : m_rf[c.rn];
      b = m_rf[c.rm];
      case (c.shift)
        2'd1: b = (b * 2) & msk;
        2'd2: b = b / 2;
        2'd3: b = (sgn(b) >>> 1) & msk;
        default: ;
      endcase
      if (c.bsel) b = longint'(c.imm) & msk;
      v = 1'b0;
      case (c.aluop)
        2'd0: begin full = sgn(a) + sgn(b); r = full & msk; v = (full < -half) || (full >= half); end
        2'd1: begin full = sgn(a) - sgn(b); r = full & msk; v = (full < -half) || (full >= half); end
        2'd2: r = a & b;
        default: r = (~b) & msk;
      endcase
      m_c = r;
      if (c.sen) m_st = {r == 0, v, r >= half};
      val = m_c;
    end else if (c.wsrc == 2'b01) val = longint'(c.mdata) & msk;
    else if (c.wsrc == 2'b10) val = longint'(c.imm) & msk;
    else val = longint'(c.pc);
    if (c.wen) m_rf[c.rd] = val;
  endtask

  // Issues one command; returns the cycle (after the accept edge) in which done was seen
  task automatic exec_cmd(input cmd_t c, output int lat);
    int n = 0;
    @(negedge clk);
    drive(c);
    valid = 1'b1;
    while (ready_s !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("accept timeout", 64'(ready_s), 64'd1);
    @(posedge clk);
    #1;
    valid = 1'b0;
    drive(rand_cmd(16));
    lat = 0;
    do begin @(negedge clk); lat++; end while (done_s !== 1'b1 && lat < 12);
  endtask

  task automatic do_model_cmd(input cmd_t c, input string tag);
    int lat;
    exec_cmd(c, lat);
    model(c);
    chk({tag, " latency"}, 64'(lat), (c.wsrc == 2'b00) ? 64'd4 : 64'd1);
    @(negedge clk);
    dbg_addr = c.rd;
    #1;
    chk({tag, " dout"}, 64'(dout_s), m_c);
    chk({tag, " status"}, 64'(st_s), 64'(m_st));
    chk({tag, " rf"}, 64'(dbg_s), m_rf[c.rd]);
    chk({tag, " ready"}, 64'(ready_s), 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic check_all_regs(input string tag, input int nreg);
    for (int i = 0; i < nreg; i++) begin
      dbg_addr = 4'(i);
      #1;
      chk($sformatf("%s r%0d", tag, i), 64'(dbg_s), m_rf[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [13];
    cmd_t bb [3];
    int lat, n, d0;

    tbl[0]  = '{mk(0,0,0,0,0,0,0,2,1,0,7,0,0), 1, 32'h7, 32'h0, 3'b000};
    tbl[1]  = '{mk(1,0,0,0,0,0,0,2,1,0,2,0,0), 1, 32'h2, 32'h0, 3'b000};
    tbl[2]  = '{mk(2,0,1,1,0,0,0,0,1,1,0,0,0), 4, 32'hB, 32'hB, 3'b000};
    tbl[3]  = '{mk(3,0,0,0,0,0,0,2,1,0,32'hFFFF_8000,0,0), 1, 32'h8000, 32'hB, 3'b000};
    tbl[4]  = '{mk(4,0,0,0,0,0,0,2,1,0,1,0,0), 1, 32'h1, 32'hB, 3'b000};
    tbl[5]  = '{mk(5,3,4,0,1,0,0,0,1,1,0,0,0), 4, 32'h7FFF, 32'h7FFF, 3'b010};
    tbl[6]  = '{mk(5,4,4,0,1,0,0,0,0,1,0,0,0), 4, 32'h7FFF, 32'h0, 3'b100};
    tbl[7]  = '{mk(6,0,0,0,0,0,0,1,1,0,0,32'hBEEF,0), 1, 32'hBEEF, 32'h0, 3'b100};
    tbl[8]  = '{mk(7,0,0,0,0,0,0,3,1,0,0,0,8'hA5), 1, 32'hA5, 32'h0, 3'b100};
    tbl[9]  = '{mk(6,0,3,3,3,0,0,0,1,1,0,0,0), 4, 32'h3FFF, 32'h3FFF, 3'b000};
    tbl[10] = '{mk(7,5,0,0,2,1,1,0,1,1,32'hF0,0,0), 4, 32'h0, 32'h0, 3'b100};
    tbl[11] = '{mk(1,0,3,2,0,1,0,0,1,1,0,0,0), 4, 32'h4000, 32'h4000, 3'b000};
    tbl[12] = '{mk(0,0,0,0,0,0,0,1,0,0,0,32'h5555,0), 1, 32'h7, 32'h4000, 3'b000};

    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    dbg_addr = 4'd0;
    do_reset();
    chk("reset ready", 64'(ready_s), 64'd1);
    chk("reset status", 64'(st_s), 64'd0);
    chk("reset dout", 64'(dout_s), 64'd0);
    check_all_regs("reset", 8);

    foreach (tbl[i]) begin
      exec_cmd(tbl[i].c, lat);
      model(tbl[i].c);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(tbl[i].lat));
      @(negedge clk);
      dbg_addr = tbl[i].c.rd;
      #1;
      chk($sformatf("vec%0d rf", i), 64'(dbg_s), 64'(tbl[i].rf_exp));
      chk($sformatf("vec%0d dout", i), 64'(dout_s), 64'(tbl[i].dout_exp));
      chk($sformatf("vec%0d status", i), 64'(st_s), 64'(tbl[i].st_exp));
    end

    // Back-to-back with valid held high; first command reads and writes the same register
    bb[0] = mk(2,2,2,0,0,0,0,0,1,1,0,0,0);
    bb[1] = mk(0,0,0,0,0,0,0,2,1,0,32'h1234,0,0);
    bb[2] = mk(3,0,2,0,1,0,0,0,1,1,0,0,0);
    d0 = done_cnt;
    @(negedge clk);
    drive(bb[0]);
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      model(bb[i]);
      if (i < 2) drive(bb[i + 1]);
      else begin valid = 1'b0; drive(rand_cmd(8)); end
      n = 0;
      do begin @(negedge clk); n++; end while (ready_s !== 1'b1 && n < 20);
      chk($sformatf("b2b gap%0d", i), 64'(n), (bb[i].wsrc == 2'b00) ? 64'd5 : 64'd2);
    end
    chk("b2b done count", 64'(done_cnt - d0), 64'd3);
    chk("b2b dout", 64'(dout_s), m_c);
    check_all_regs("b2b", 8);

    for (int i = 0; i < 40; i++) do_model_cmd(rand_cmd(8), $sformatf("rnd16_%0d", i));

    // Reset in EXEC drops the command
    d0 = done_cnt;
    @(negedge clk);
    drive(mk(6,1,1,0,0,0,0,0,1,1,0,0,0));
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst-exec ready", 64'(ready_s), 64'd1);
    repeat (4) @(negedge clk);
    chk("rst-exec no done", 64'(done_cnt - d0), 64'd0);
    chk("rst-exec status", 64'(st_s), 64'd0);
    check_all_regs("rst-exec", 8);

    // Wide instance
    sel32 = 1'b1;
    W = 32;
    do_reset();
    do_model_cmd(mk(3,0,0,0,0,0,0,2,1,0,32'h8000_0000,0,0), "w32 ld3");
    do_model_cmd(mk(4,0,0,0,0,0,0,2,1,0,1,0,0), "w32 ld4");
    do_model_cmd(mk(5,3,4,0,1,0,0,0,1,1,0,0,0), "w32 sub");
    dbg_addr = 4'd5;
    #1;
    chk("w32 sub value", 64'(dbg_s), 64'h7FFF_FFFF);
    chk("w32 sub status", 64'(st_s), 64'b010);
    do_model_cmd(mk(5,4,4,0,1,0,0,0,0,1,0,0,0), "w32 cmp");
    chk("w32 cmp status", 64'(st_s), 64'b100);
    chk("w32 cmp keeps rf", 64'(dbg_s), 64'h7FFF_FFFF);
    do_model_cmd(mk(15,0,0,0,0,0,0,3,1,0,0,0,8'hC3), "w32 pc15");
    for (int i = 0; i < 25; i++) do_model_cmd(rand_cmd(16), $sformatf("rnd32_%0d", i));
    check_all_regs("w32 final", 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
